// File: rtl/instr_mem_ctrl.sv
// Run-time loadable instruction memory. A valid/ready load port fills the array,
// and a registered fetch port reads it back with bounds checking in RUN.
module instr_mem_ctrl #(
  parameter int              A   = 10,
  parameter int              W   = 9,
  parameter logic [W-1:0]    NOP = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_start,
  input  logic           load_valid,
  input  logic [W-1:0]   load_data,
  input  logic           load_last,
  output logic           load_ready,
  output logic           load_done,
  output logic [A:0]     load_count,
  input  logic           fetch_req,
  input  logic [A-1:0]   fetch_addr,
  output logic [W-1:0]   instr_out,
  output logic           instr_valid,
  output logic           addr_err,
  output logic [1:0]     state_dbg
);

  localparam int DEPTH = 2 ** A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   wptr_q, wptr_d;
  logic [A:0]     load_count_q, load_count_d;
  logic           load_done_q, load_done_d;
  logic [W-1:0]   instr_q, instr_d;
  logic           instr_valid_q, instr_valid_d;
  logic           addr_err_q, addr_err_d;
  logic           mem_we;

  logic [W-1:0]   mem [DEPTH];

  // Handshake: a load word transfers on a rising edge where load_valid and
  // load_ready are both high; load_start in the same cycle discards the word.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    load_count_d  = load_count_q;
    load_done_d   = load_done_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    mem_we        = 1'b0;
    load_ready    = (state_q == LOAD);

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          wptr_d       = '0;
          load_count_d = '0;
        end else if (load_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + A'(1);
          // The last array slot ends the load even without load_last.
          if (load_last || (&wptr_q)) begin
            state_d      = RUN;
            load_count_d = {1'b0, wptr_q} + (A+1)'(1);
            load_done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_d      = LOAD;
          load_done_d  = 1'b0;
          load_count_d = '0;
          wptr_d       = '0;
        end else if (fetch_req) begin
          instr_valid_d = 1'b1;
          if ({1'b0, fetch_addr} < load_count_q) begin
            instr_d = mem[fetch_addr];
          end else begin
            instr_d    = NOP;
            addr_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      load_count_q  <= '0;
      load_done_q   <= 1'b0;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_count_q  <= load_count_d;
      load_done_q   <= load_done_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Array contents survive reset; load_count=0 makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= load_data;
  end

  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign instr_out   = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: a 1024-word instance for the main flows
// and a 16-word instance for the auto-terminating full load.
module tb_instr_mem_ctrl;
  localparam int W  = 9;
  localparam int A  = 10;
  localparam int A4 = 4;
  localparam logic [W-1:0] NOP = '0;

  logic clk, rst_n;

  // 1024-word instance
  logic          load_start, load_valid, load_last, fetch_req;
  logic [W-1:0]  load_data;
  logic [A-1:0]  fetch_addr;
  logic          load_ready, load_done, instr_valid, addr_err;
  logic [A:0]    load_count;
  logic [W-1:0]  instr_out;
  logic [1:0]    state_dbg;

  // 16-word instance
  logic          load_start4, load_valid4, load_last4, fetch_req4;
  logic [W-1:0]  load_data4;
  logic [A4-1:0] fetch_addr4;
  logic          load_ready4, load_done4, instr_valid4, addr_err4;
  logic [A4:0]   load_count4;
  logic [W-1:0]  instr_out4;
  logic [1:0]    state_dbg4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] exp4_q[$];
  logic [W:0] exp_v, exp4_v;

  instr_mem_ctrl #(.A(A), .W(W), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_out(instr_out), .instr_valid(instr_valid), .addr_err(addr_err),
    .state_dbg(state_dbg)
  );

  instr_mem_ctrl #(.A(A4), .W(W), .NOP(NOP)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start4), .load_valid(load_valid4), .load_data(load_data4),
    .load_last(load_last4), .load_ready(load_ready4), .load_done(load_done4),
    .load_count(load_count4), .fetch_req(fetch_req4), .fetch_addr(fetch_addr4),
    .instr_out(instr_out4), .instr_valid(instr_valid4), .addr_err(addr_err4),
    .state_dbg(state_dbg4)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic load_word(input logic [W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [A-1:0] addr, input logic err, input logic [W-1:0] exp_instr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    exp_q.push_back({err, exp_instr});
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic fetch4(input logic [A4-1:0] addr, input logic err, input logic [W-1:0] exp_instr);
    fetch_req4  = 1'b1;
    fetch_addr4 = addr;
    exp4_q.push_back({err, exp_instr});
    tick();
    fetch_req4  = 1'b0;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fetch: got instr=0x%0h err=%0b, expected no response", instr_out, addr_err);
      end else begin
        exp_v = exp_q.pop_front();
        if ({addr_err, instr_out} !== exp_v) begin
          n_fail++;
          $display("FAIL fetch_resp: got err=%0b instr=0x%0h, expected err=%0b instr=0x%0h",
                   addr_err, instr_out, exp_v[W], exp_v[W-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid4) begin
      n_checks++;
      if (exp4_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fetch4: got instr=0x%0h err=%0b, expected no response", instr_out4, addr_err4);
      end else begin
        exp4_v = exp4_q.pop_front();
        if ({addr_err4, instr_out4} !== exp4_v) begin
          n_fail++;
          $display("FAIL fetch_resp4: got err=%0b instr=0x%0h, expected err=%0b instr=0x%0h",
                   addr_err4, instr_out4, exp4_v[W], exp4_v[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_req = 0; fetch_addr = '0;
    load_start4 = 0; load_valid4 = 0; load_last4 = 0; load_data4 = '0;
    fetch_req4 = 0; fetch_addr4 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_instr_out",   32'(instr_out),   32'(NOP));
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_load_ready",  32'(load_ready),  0);
    check("rst_load_done",   32'(load_done),   0);
    check("rst_load_count",  32'(load_count),  0);
    check("rst_state",       32'(state_dbg),   0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch in IDLE is ignored
    fetch_req = 1'b1; fetch_addr = '0;
    tick();
    fetch_req = 1'b0;
    check("idle_fetch_valid", 32'(instr_valid), 0);
    check("idle_fetch_instr", 32'(instr_out),   32'(NOP));
    check("idle_load_ready",  32'(load_ready),  0);

    // Three-word load with idle gaps
    start_load();
    check("load_ready_in_load", 32'(load_ready), 1);
    load_word(9'h001, 1'b0);
    tick();
    load_word(9'h0A5, 1'b0);
    tick();
    check("load_done_before_last", 32'(load_done), 0);
    load_word(9'h1FF, 1'b1);
    check("load_done_3",  32'(load_done),  1);
    check("load_count_3", 32'(load_count), 3);
    check("ready_in_run", 32'(load_ready), 0);
    check("state_run",    32'(state_dbg),  2);

    fetch(10'd1, 1'b0, 9'h0A5);
    fetch_req = 1'b1; fetch_addr = 10'd3; exp_q.push_back({1'b1, NOP});
    tick();
    fetch_addr = 10'd2; exp_q.push_back({1'b0, 9'h1FF});
    tick();
    fetch_req = 1'b0;
    tick();
    check("hold_valid", 32'(instr_valid), 0);
    check("hold_instr", 32'(instr_out),   32'h1FF);
    check("hold_err",   32'(addr_err),    0);
    fetch(10'd0, 1'b0, 9'h001);
    fetch(10'd1023, 1'b1, NOP);
    tick();

    // Restart inside LOAD discards the coincident word
    start_load();
    check("reload_done_clr",  32'(load_done),  0);
    check("reload_count_clr", 32'(load_count), 0);
    load_word(9'h011, 1'b0);
    load_word(9'h022, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_data = 9'h0EE;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    check("restart_count", 32'(load_count), 0);
    check("restart_ready", 32'(load_ready), 1);
    load_word(9'h033, 1'b0);
    load_word(9'h044, 1'b1);
    check("restart_count_2", 32'(load_count), 2);
    fetch(10'd0, 1'b0, 9'h033);
    fetch(10'd1, 1'b0, 9'h044);
    fetch(10'd2, 1'b1, NOP);
    tick();

    // load_start beats fetch_req in RUN
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 10'd0;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    check("collide_valid", 32'(instr_valid), 0);
    check("collide_done",  32'(load_done),   0);
    check("collide_state", 32'(state_dbg),   1);

    // Reset mid-load
    for (int i = 0; i < 5; i++) load_word(9'(9'h050 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_done",  32'(load_done),  0);
    check("midrst_count", 32'(load_count), 0);
    check("midrst_state", 32'(state_dbg),  0);
    check("midrst_ready", 32'(load_ready), 0);
    tick();
    rst_n = 1'b1;
    fetch_req = 1'b1; fetch_addr = 10'd0;
    tick();
    fetch_req = 1'b0;
    check("postrst_fetch_valid", 32'(instr_valid), 0);
    start_load();
    load_word(9'h155, 1'b1);
    check("postrst_count", 32'(load_count), 1);
    fetch(10'd0, 1'b0, 9'h155);
    fetch(10'd1, 1'b1, NOP);
    tick();

    // 16-word array fills and auto-terminates
    load_start4 = 1'b1;
    tick();
    load_start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        check("a4_ready_before_16", 32'(load_ready4), 1);
        check("a4_done_before_16",  32'(load_done4),  0);
      end
      load_valid4 = 1'b1; load_data4 = 9'(9'h100 + i);
      tick();
    end
    load_data4 = 9'h0DD;
    check("a4_done",  32'(load_done4),  1);
    check("a4_count", 32'(load_count4), 16);
    check("a4_ready", 32'(load_ready4), 0);
    tick();
    load_valid4 = 1'b0;
    check("a4_count_after_extra", 32'(load_count4), 16);
    fetch4(4'd15, 1'b0, 9'h10F);
    fetch4(4'd0,  1'b0, 9'h100);
    fetch4(4'd7,  1'b0, 9'h107);

    repeat (4) tick();
    check("drain_q",  32'(exp_q.size()),  0);
    check("drain_q4", 32'(exp4_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
